// File: rtl/panel_lamp_scan.sv
// Avalon-MM master that sweeps panel registers FIRST_ADDR..LAST_ADDR and shifts each word into a lamp chain.
// Optional macro PANEL_LAMP_SCAN_PARITY_EN appends an odd-parity bit after every word's data bits.

module panel_lamp_scan #(
    parameter logic [5:0]  FIRST_ADDR = 6'o10,
    parameter logic [5:0]  LAST_ADDR  = 6'o35,
    parameter int unsigned SHIFT_BITS = 25,
    parameter int unsigned CLK_DIV    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    output logic [5:0]  m_address,
    output logic        m_read,
    input  logic [31:0] m_readdata,
    input  logic        m_waitrequest,
    output logic        lamp_sclk,
    output logic        lamp_sdata,
    output logic        lamp_latch,
    output logic        busy,
    output logic        frame_done
);

`ifdef PANEL_LAMP_SCAN_PARITY_EN
    localparam int unsigned PAR_BITS = 1;
`else
    localparam int unsigned PAR_BITS = 0;
`endif
    localparam int unsigned WORD_BITS = SHIFT_BITS + PAR_BITS;
    localparam int unsigned DIV_W     = $clog2(CLK_DIV + 1);
    localparam int unsigned CNT_W     = 6;
    localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(CLK_DIV);
    localparam logic [CNT_W-1:0] BIT_LOAD = CNT_W'(WORD_BITS);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        SHIFT_LO,
        SHIFT_HI,
        LATCH
    } state_e;

    state_e                 state_q, state_d;
    logic [5:0]             addr_q, addr_d;
    logic [WORD_BITS-1:0]   shreg_q, shreg_d;
    logic [CNT_W-1:0]       bitcnt_q, bitcnt_d;
    logic [DIV_W-1:0]       divcnt_q, divcnt_d;
    logic                   m_read_q, m_read_d;
    logic                   sclk_q, sclk_d;
    logic                   sdata_q, sdata_d;
    logic                   latch_q, latch_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic [SHIFT_BITS-1:0]  word_data;
    logic [WORD_BITS-1:0]   shreg_load;
    logic                   div_last;
    logic                   unused_rdata;

    assign word_data    = m_readdata[SHIFT_BITS-1:0];
    assign unused_rdata = ^m_readdata;
    assign div_last     = (divcnt_q == DIV_W'(1));

    // Parity bit sits below the data so it leaves the chain last.
`ifdef PANEL_LAMP_SCAN_PARITY_EN
    assign shreg_load = {word_data, ~(^word_data)};
`else
    assign shreg_load = word_data;
`endif

    // Next-state, datapath and next-output logic; outputs are registered from next-state values.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        shreg_d  = shreg_q;
        bitcnt_d = bitcnt_q;
        divcnt_d = divcnt_q;

        case (state_q)
            IDLE: begin
                addr_d = FIRST_ADDR;
                if (enable) begin
                    state_d = READ;
                end
            end
            READ: begin
                if (!m_waitrequest) begin
                    shreg_d  = shreg_load;
                    bitcnt_d = BIT_LOAD;
                    divcnt_d = DIV_LOAD;
                    state_d  = SHIFT_LO;
                end
            end
            SHIFT_LO: begin
                if (div_last) begin
                    divcnt_d = DIV_LOAD;
                    state_d  = SHIFT_HI;
                end else begin
                    divcnt_d = divcnt_q - DIV_W'(1);
                end
            end
            SHIFT_HI: begin
                if (div_last) begin
                    shreg_d  = shreg_q << 1;
                    bitcnt_d = bitcnt_q - CNT_W'(1);
                    divcnt_d = DIV_LOAD;
                    if (bitcnt_q != CNT_W'(1)) begin
                        state_d = SHIFT_LO;
                    end else if (addr_q != LAST_ADDR) begin
                        addr_d  = addr_q + 6'd1;
                        state_d = READ;
                    end else begin
                        state_d = LATCH;
                    end
                end else begin
                    divcnt_d = divcnt_q - DIV_W'(1);
                end
            end
            LATCH: begin
                if (div_last) begin
                    addr_d  = FIRST_ADDR;
                    state_d = enable ? READ : IDLE;
                end else begin
                    divcnt_d = divcnt_q - DIV_W'(1);
                end
            end
            default: begin
                addr_d  = FIRST_ADDR;
                state_d = IDLE;
            end
        endcase

        m_read_d = (state_d == READ);
        sclk_d   = (state_d == SHIFT_HI);
        latch_d  = (state_d == LATCH);
        busy_d   = (state_d != IDLE);
        done_d   = (state_d == LATCH) && (divcnt_d == DIV_W'(1));

        case (state_d)
            SHIFT_LO: sdata_d = shreg_d[WORD_BITS-1];
            SHIFT_HI: sdata_d = sdata_q;
            default:  sdata_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            addr_q   <= FIRST_ADDR;
            shreg_q  <= '0;
            bitcnt_q <= '0;
            divcnt_q <= '0;
            m_read_q <= 1'b0;
            sclk_q   <= 1'b0;
            sdata_q  <= 1'b0;
            latch_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            shreg_q  <= shreg_d;
            bitcnt_q <= bitcnt_d;
            divcnt_q <= divcnt_d;
            m_read_q <= m_read_d;
            sclk_q   <= sclk_d;
            sdata_q  <= sdata_d;
            latch_q  <= latch_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign m_address  = addr_q;
    assign m_read     = m_read_q;
    assign lamp_sclk  = sclk_q;
    assign lamp_sdata = sdata_q;
    assign lamp_latch = latch_q;
    assign busy       = busy_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_panel_lamp_scan.sv
// Bench for panel_lamp_scan: Avalon slave with random wait states, lamp-chain monitor and frame-level model.
// Honours PANEL_LAMP_SCAN_PARITY_EN the same way the design does.

module tb_panel_lamp_scan;

    localparam logic [5:0] FIRST = 6'd2;
    localparam logic [5:0] LAST  = 6'd4;
    localparam int SB = 4;
    localparam int CD = 2;
`ifdef PANEL_LAMP_SCAN_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int NB        = SB + PB;
    localparam int NW        = int'(LAST) - int'(FIRST) + 1;
    localparam int WORD_CYC  = 1 + 2 * NB * CD;
    localparam int FRAME_CYC = NW * WORD_CYC + CD;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [5:0]  m_address;
    logic        m_read;
    logic [31:0] m_readdata;
    logic        m_waitrequest = 1'b0;
    logic        lamp_sclk, lamp_sdata, lamp_latch, busy, frame_done;

    int total = 0;
    int bad = 0;

    panel_lamp_scan #(
        .FIRST_ADDR(FIRST),
        .LAST_ADDR (LAST),
        .SHIFT_BITS(SB),
        .CLK_DIV   (CD)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .m_address    (m_address),
        .m_read       (m_read),
        .m_readdata   (m_readdata),
        .m_waitrequest(m_waitrequest),
        .lamp_sclk    (lamp_sclk),
        .lamp_sdata   (lamp_sdata),
        .lamp_latch   (lamp_latch),
        .busy         (busy),
        .frame_done   (frame_done)
    );

    always #5 clk = ~clk;

    // Slave memory; junk is presented while a wait state is in force.
    logic [31:0] mem [64];
    logic [31:0] junk = 32'h0;
    assign m_readdata = m_waitrequest ? junk : mem[m_address];

    int         wait_plan[$];
    int         wait_log[$];
    logic [5:0] addr_log[$];
    int         rdlen_q[$];
    int         max_wait = 0;
    int         wait_left = 0;
    int         rd_len = 0;
    int         proto_err = 0;
    bit         in_read = 1'b0;
    logic [5:0] rd_addr = 6'd0;

    always @(negedge clk) begin
        junk = $urandom;
        if (m_read === 1'b1) begin
            rd_len++;
            if (in_read && !m_waitrequest) proto_err++;
            if (!in_read) begin
                in_read = 1'b1;
                rd_addr = m_address;
                if (wait_plan.size() > 0) wait_left = wait_plan.pop_front();
                else wait_left = int'($urandom_range(max_wait, 0));
                wait_log.push_back(wait_left);
                addr_log.push_back(m_address);
            end else if (m_address !== rd_addr) begin
                proto_err++;
            end
            m_waitrequest = (wait_left != 0);
            if (wait_left != 0) wait_left--;
        end else begin
            if (in_read && m_waitrequest) proto_err++;
            if (rd_len > 0) rdlen_q.push_back(rd_len);
            rd_len = 0;
            in_read = 1'b0;
            m_waitrequest = 1'b0;
        end
    end

    // Lamp-chain and frame monitor.
    bit   bits_q[$];
    int   start_q[$];
    int   done_q[$];
    int   cyc = 0;
    int   latch_cyc = 0;
    int   overlap_err = 0;
    int   done_err = 0;
    int   sclk_err = 0;
    int   busy_err = 0;
    int   hi_run = 0;
    bit   in_frame = 1'b0;
    logic sclk_prev = 1'b0;
    logic sdata_prev = 1'b0;
    logic read_prev = 1'b0;
    logic done_prev = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (lamp_sclk === 1'b1 && sclk_prev !== 1'b1) bits_q.push_back(lamp_sdata);
        if (lamp_sclk === 1'b1 && sclk_prev === 1'b1 && lamp_sdata !== sdata_prev) sclk_err++;
        if (lamp_sclk === 1'b1) hi_run++;
        else if (sclk_prev === 1'b1) begin
            if (hi_run != CD) sclk_err++;
            hi_run = 0;
        end
        if (m_read === 1'b1 && read_prev !== 1'b1 && m_address === FIRST) begin
            start_q.push_back(cyc);
            in_frame = 1'b1;
        end
        if (reset) in_frame = 1'b0;
        else if (in_frame && busy !== 1'b1) busy_err++;
        if (frame_done === 1'b1) begin
            done_q.push_back(cyc);
            in_frame = 1'b0;
            if (lamp_latch !== 1'b1 || done_prev === 1'b1) done_err++;
        end
        if (lamp_latch === 1'b1) latch_cyc++;
        if (lamp_latch === 1'b1 && lamp_sclk === 1'b1) overlap_err++;
        sclk_prev  = lamp_sclk;
        sdata_prev = lamp_sdata;
        read_prev  = m_read;
        done_prev  = frame_done;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic clear_logs();
        bits_q.delete();
        start_q.delete();
        done_q.delete();
        wait_log.delete();
        addr_log.delete();
        rdlen_q.delete();
    endtask

    // Expected lamp bits: each word's low SB bits MSB first, then odd parity if enabled.
    bit exp_q[$];
    task automatic build_expected(input int nf);
        logic [31:0] d;
        int ones;
        exp_q.delete();
        for (int f = 0; f < nf; f++) begin
            for (int a = 0; a < NW; a++) begin
                d = mem[int'(FIRST) + a];
                ones = 0;
                for (int i = SB - 1; i >= 0; i--) begin
                    exp_q.push_back(d[i]);
                    ones += int'(d[i]);
                end
                if (PB == 1) exp_q.push_back(ones % 2 == 0);
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_addr"},  32'(m_address),  32'(FIRST));
        check({tag, "_read"},  32'(m_read),     0);
        check({tag, "_sclk"},  32'(lamp_sclk),  0);
        check({tag, "_sdata"}, 32'(lamp_sdata), 0);
        check({tag, "_latch"}, 32'(lamp_latch), 0);
        check({tag, "_busy"},  32'(busy),       0);
        check({tag, "_done"},  32'(frame_done), 0);
    endtask

    // Runs nf frames (single enable pulse when nf==1, otherwise enable held) and checks them.
    task automatic run_frames(input int nf, input int mw);
        int lim, t, mism, wsum, latch0;
        clear_logs();
        build_expected(nf);
        max_wait = mw;
        latch0 = latch_cyc;
        enable = 1'b1;
        step(1);
        if (nf == 1) enable = 1'b0;
        lim = nf * (FRAME_CYC + NW * (mw + 1)) + 50;
        t = 0;
        while (done_q.size() < nf && t < lim) begin
            step(1);
            t++;
        end
        enable = 1'b0;
        check("frames_done", done_q.size(), nf);
        step(CD + 3);
        check("after_busy",  32'(busy),      0);
        check("after_addr",  32'(m_address), 32'(FIRST));
        check("after_read",  32'(m_read),    0);
        check("after_latch", 32'(lamp_latch), 0);
        check("bit_count", bits_q.size(), exp_q.size());
        mism = 0;
        for (int i = 0; i < bits_q.size() && i < exp_q.size(); i++)
            if (bits_q[i] != exp_q[i]) mism++;
        check("bit_values", mism, 0);
        check("read_count", addr_log.size(), nf * NW);
        mism = 0;
        for (int i = 0; i < addr_log.size(); i++)
            if (addr_log[i] !== 6'(int'(FIRST) + i % NW)) mism++;
        check("read_addrs", mism, 0);
        check("frame_starts", start_q.size(), nf);
        if (start_q.size() == nf && done_q.size() == nf && wait_log.size() == nf * NW) begin
            for (int f = 0; f < nf; f++) begin
                wsum = 0;
                for (int j = 0; j < NW; j++) wsum += wait_log[f * NW + j];
                check("frame_len", done_q[f] - start_q[f], FRAME_CYC + wsum - 1);
                if (f > 0) check("frame_gap", start_q[f] - done_q[f - 1], 1);
            end
        end
        check("latch_cycles", latch_cyc - latch0, nf * CD);
    endtask

    initial begin
        int t, latch0, nf;
        for (int i = 0; i < 64; i++) mem[i] = $urandom;

        reset = 1'b1;
        step(3);
        check_reset_outputs("rst");
        reset = 1'b0;
        step(4);
        check("idle_busy", 32'(busy), 0);

        // Directed frame with upper readdata bits set to catch over-wide capture.
        mem[2] = 32'hF234_567A;
        mem[3] = 32'hABCD_EF05;
        mem[4] = 32'h0000_000C;
        run_frames(1, 0);

        // Three wait states on the first read of the frame.
        wait_plan.push_back(3);
        run_frames(1, 0);
        check("wait_read_len", rdlen_q.size() > 0 ? rdlen_q[0] : -1, 4);
        check("wait_frame_len", (done_q.size() > 0 && start_q.size() > 0) ? done_q[0] - start_q[0] : -1,
              FRAME_CYC + 3 - 1);

        // Continuous run with constant data.
        run_frames(3, 0);

        // Reset during the low phase of bit 3 of word 0.
        clear_logs();
        latch0 = latch_cyc;
        enable = 1'b1;
        step(1);
        enable = 1'b0;
        t = 0;
        while (!(bits_q.size() >= 2 && lamp_sclk === 1'b0) && t < 200) begin
            step(1);
            t++;
        end
        check("reach_bit3", bits_q.size(), 2);
        reset = 1'b1;
        step(1);
        check_reset_outputs("midrst");
        reset = 1'b0;
        step(3 * FRAME_CYC);
        check("midrst_no_latch", latch_cyc - latch0, 0);
        check("midrst_no_done", done_q.size(), 0);
        check("midrst_idle", 32'(busy), 0);

        // Random data and wait states.
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < 64; i++) mem[i] = $urandom;
            nf = int'($urandom_range(3, 1));
            run_frames(nf, 3);
        end

        check("protocol", proto_err, 0);
        check("latch_sclk_overlap", overlap_err, 0);
        check("done_pulse", done_err, 0);
        check("sclk_shape", sclk_err, 0);
        check("busy_in_frame", busy_err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/panel_lamp_scan.md
Name: panel_lamp_scan

Overview:
- Avalon-MM master that sits directly upstream of the KA10 operator/maintenance panel slave.
- Sweeps a contiguous range of panel register addresses, one read per word, and serializes each word out to an external shift-register lamp chain.
- Pulses a latch after each full frame so all lamps update at once.
- Replaces software polling for driving a physical light panel.

Parameters:
- FIRST_ADDR, 6'o10, first panel register read in a frame.
- LAST_ADDR, 6'o35, last panel register read in a frame, inclusive; must be >= FIRST_ADDR.
- SHIFT_BITS, 25, low-order readdata bits shifted per word, MSB first; range 1..32.
- CLK_DIV, 4, clk cycles per lamp_sclk half-period; minimum 1.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  run continuous frames while high
- m_address  out  6  Avalon master address to the panel slave
- m_read  out  1  Avalon read strobe
- m_readdata  in  32  Avalon read data
- m_waitrequest  in  1  Avalon wait; read completes in a cycle with m_read=1 and m_waitrequest=0
- lamp_sclk  out  1  lamp chain shift clock; data is sampled on its rising edge
- lamp_sdata  out  1  lamp chain serial data
- lamp_latch  out  1  lamp chain output-register strobe
- busy  out  1  high whenever the FSM is not IDLE
- frame_done  out  1  one-cycle pulse at frame end

Behaviour:
- Clock and reset:
  - One clock: clk.
  - reset is synchronous and active-high.
  - Reset outputs: m_address=FIRST_ADDR, m_read=0, lamp_sclk=0, lamp_sdata=0, lamp_latch=0, busy=0, frame_done=0.
  - Reset taken mid-read, mid-shift or mid-latch aborts immediately. No partial latch is ever issued.
- States: IDLE, READ, SHIFT_LO, SHIFT_HI, LATCH.
- IDLE:
  - Outputs at reset values.
  - enable=1 -> READ with m_address=FIRST_ADDR.
- READ:
  - m_read=1; m_address held stable.
  - While m_waitrequest=1, stay in READ, unchanged.
  - On the cycle with m_waitrequest=0, capture m_readdata[SHIFT_BITS-1:0] into the shift register, load bit counter=SHIFT_BITS, go to SHIFT_LO.
  - m_read is 0 in the following cycle.
- SHIFT_LO:
  - lamp_sclk=0; lamp_sdata = current MSB of the shift register.
  - Hold CLK_DIV cycles, then go to SHIFT_HI.
- SHIFT_HI:
  - lamp_sclk=1; lamp_sdata unchanged.
  - Hold CLK_DIV cycles.
  - On exit: shift left one bit and decrement the counter.
  - Counter nonzero -> SHIFT_LO.
  - Counter zero and m_address != LAST_ADDR -> increment m_address, go to READ.
  - Counter zero and m_address == LAST_ADDR -> LATCH.
- LATCH:
  - lamp_sclk=0, lamp_latch=1 for CLK_DIV cycles.
  - frame_done=1 in the last of those cycles.
  - Next: m_address=FIRST_ADDR; enable=1 -> READ, else IDLE.
- Timing:
  - Per word: 1 + 2*SHIFT_BITS*CLK_DIV cycles, assuming no wait states.
  - Frame: N*(1 + 2*SHIFT_BITS*CLK_DIV) + CLK_DIV cycles, with N = LAST_ADDR - FIRST_ADDR + 1.
- enable:
  - Sampled only in IDLE and at LATCH exit.
  - Deasserting mid-frame completes the current frame, including its latch.
- Counters:
  - Divider counter is ceil(log2(CLK_DIV+1)) bits.
  - Bit counter is 6 bits.
  - No wrap-around of m_address past LAST_ADDR.
- lamp_latch and lamp_sclk are never high in the same cycle.

Optional Feature:
- Macro: PANEL_LAMP_SCAN_PARITY_EN.
- When defined: after each word's SHIFT_BITS data bits, one extra odd-parity bit (XOR of the data bits, inverted) is shifted with the same LO/HI timing. Per-word bit count becomes SHIFT_BITS+1.
- When undefined: no parity bit is shifted; timing is exactly as above.

Test Plan:
- Two-word frame: FIRST_ADDR=0, LAST_ADDR=1, SHIFT_BITS=4, CLK_DIV=1, no wait states, readdata 0xA at address 0 and 0x5 at address 1, enable pulsed high for 1 cycle.
  - lamp_sdata sampled on sclk rising edges = 1,0,1,0,0,1,0,1.
  - lamp_latch high for 1 cycle; frame_done pulses in cycle 18 counted from READ entry (cycle 0).
  - Then IDLE, busy=0.
- Wait states: m_waitrequest held 1 for 3 cycles during the first READ.
  - m_read and m_address stay stable for 4 cycles.
  - Data captured only on the 4th cycle; shift sequence unchanged; frame_done delayed by 3 cycles.
- Continuous run: enable held 1.
  - The READ at FIRST_ADDR follows the LATCH exit with zero idle cycles.
  - Two consecutive frames are bit-identical for constant readdata.
- Mid-shift reset: assert reset during the 3rd bit of word 0.
  - Next cycle: all outputs at reset values, lamp_latch never pulses, m_address=FIRST_ADDR.
- CLK_DIV=3, SHIFT_BITS=25, readdata 0x1FFFFFF:
  - lamp_sclk period is 6 cycles, 25 ones are shifted, word time is 151 cycles.
  - With PANEL_LAMP_SCAN_PARITY_EN defined, a 26th bit = 0 is shifted.
- Parity: PANEL_LAMP_SCAN_PARITY_EN defined, SHIFT_BITS=4, readdata 0xA.
  - Shifted bits = 1,0,1,0,1; word time is 11 cycles at CLK_DIV=1.
